// File: rtl/lock_pkg.sv
// Shared types and seven-segment constants for the code lock controller.
package lock_pkg;

  typedef enum logic [1:0] {UNSET, ARMED, OPEN, ALERT} lock_state_t;

  // Segments active-high, bit0=a .. bit6=g, bit7=dp (always off).
  localparam logic [7:0] SEG_0     = 8'h3F;
  localparam logic [7:0] SEG_1     = 8'h06;
  localparam logic [7:0] SEG_2     = 8'h5B;
  localparam logic [7:0] SEG_3     = 8'h4F;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'h6D;
  localparam logic [7:0] SEG_6     = 8'h7D;
  localparam logic [7:0] SEG_7     = 8'h07;
  localparam logic [7:0] SEG_8     = 8'h7F;
  localparam logic [7:0] SEG_9     = 8'h6F;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? v : v - 4'd1;
  endfunction

endpackage

// File: rtl/seg7_digit.sv
// Combinational BCD digit to seven-segment decoder; codes above 9 blank the digit.
module seg7_digit
  import lock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Combination-lock controller: key storage, compare, wrong-try counter,
// prescaled attempt timeout, auto-relock and latched alert.
module code_lock_ctrl
  import lock_pkg::*;
#(
  parameter int KEY_W         = 4,
  parameter int MAX_TRIES     = 5,
  parameter int TICK_DIV      = 100000000,
  parameter int TIMEOUT_TICKS = 5,
  parameter int OPEN_TICKS    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key_in,
  input  logic             enlock,
  input  logic             encmp,
  input  logic             clr_alert,
  output logic             open,
  output logic             locked,
  output logic             alert,
  output logic [7:0]       tries_seg,
  output logic [7:0]       time_seg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = $clog2(OPEN_TICKS + 1);

  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [3:0]    TIME_INIT  = 4'(TIMEOUT_TICKS);
  localparam logic [OW-1:0] OPEN_INIT  = OW'(OPEN_TICKS);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICK_DIV - 1);

  lock_state_t      state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       tries_q, tries_d, time_q, time_d;
  logic             run_q, run_d;
  logic [OW-1:0]    open_left_q, open_left_d;
  logic [PW-1:0]    presc_q;
  logic             en_s, en_d, cmp_s, cmp_d;
  logic             open_q, alert_q;

  logic tick, en_edge, cmp_edge;

  // Two-stage request sampling: the edge is seen one cycle after the input
  // is first sampled high, so state moves on the following edge.
  assign en_edge  = en_s & ~en_d;
  assign cmp_edge = cmp_s & ~cmp_d;
  assign tick     = (presc_q == PRESC_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= UNSET;
      key_q       <= '0;
      tries_q     <= TRIES_INIT;
      time_q      <= TIME_INIT;
      run_q       <= 1'b0;
      open_left_q <= '0;
      presc_q     <= '0;
      en_s        <= 1'b0;
      en_d        <= 1'b0;
      cmp_s       <= 1'b0;
      cmp_d       <= 1'b0;
      open_q      <= 1'b0;
      alert_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      tries_q     <= tries_d;
      time_q      <= time_d;
      run_q       <= run_d;
      open_left_q <= open_left_d;
      presc_q     <= tick ? '0 : presc_q + PW'(1);
      en_s        <= enlock;
      en_d        <= en_s;
      cmp_s       <= encmp;
      cmp_d       <= cmp_s;
      open_q      <= (state_d == OPEN);
      alert_q     <= (state_d == ALERT);
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    tries_d     = tries_q;
    time_d      = time_q;
    run_d       = run_q;
    open_left_d = open_left_q;
    case (state_q)
      UNSET: begin
        if (en_edge) begin
          key_d   = key_in;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (cmp_edge && (key_in == key_q)) begin
          state_d     = OPEN;
          tries_d     = TRIES_INIT;
          time_d      = TIME_INIT;
          run_d       = 1'b0;
          open_left_d = OPEN_INIT;
        end else begin
          // A mismatch and a timer tick in the same cycle both count.
          if (cmp_edge) begin
            tries_d = sat_dec(tries_q);
            run_d   = 1'b1;
          end
          if (tick && run_q) time_d = sat_dec(time_q);
          if ((tries_d == 4'd0) || (time_d == 4'd0)) state_d = ALERT;
        end
      end
      OPEN: begin
        if (en_edge) begin
          key_d   = key_in;
          state_d = ARMED;
        end else if (tick) begin
          open_left_d = (open_left_q == '0) ? open_left_q : open_left_q - OW'(1);
          if (open_left_d == '0) state_d = ARMED;
        end
      end
      ALERT: begin
        if (clr_alert) begin
          state_d = ARMED;
          tries_d = TRIES_INIT;
          time_d  = TIME_INIT;
          run_d   = 1'b0;
        end
      end
      default: state_d = UNSET;
    endcase
  end

  assign open   = open_q;
  assign locked = ~open_q;
  assign alert  = alert_q;

  seg7_digit u_tries_seg (.digit(tries_q), .seg(tries_seg));
  seg7_digit u_time_seg  (.digit(time_q),  .seg(time_seg));

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl with TICK_DIV=4: expectations are queued
// as stimulus is driven and popped when the DUT outputs have settled.
module tb_code_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in = 4'h0;
  logic       enlock = 1'b0, encmp = 1'b0, clr_alert = 1'b0;
  logic       open, locked, alert;
  logic [7:0] tries_seg, time_seg;

  int checks = 0;
  int failures = 0;
  int phase = 0;

  typedef struct {
    string       name;
    logic [18:0] v;
    logic [18:0] m;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [18:0] obs;

  assign obs = {open, locked, alert, tries_seg, time_seg};

  code_lock_ctrl #(.KEY_W(4), .MAX_TRIES(5), .TICK_DIV(4), .TIMEOUT_TICKS(5), .OPEN_TICKS(3)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .enlock(enlock), .encmp(encmp),
    .clr_alert(clr_alert), .open(open), .locked(locked), .alert(alert),
    .tries_seg(tries_seg), .time_seg(time_seg)
  );

  always #5 clk = ~clk;

  // Prescaler phase as defined for the block: 0..3, cleared by reset.
  always @(posedge clk) begin
    if (rst) phase <= 0;
    else     phase <= (phase == 3) ? 0 : phase + 1;
  end

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; 9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  // tm < 0 leaves time_seg unchecked.
  function automatic exp_t mk(input string name, input bit o, input bit a, input int tr, input int tm);
    exp_t x;
    x.name = name;
    x.v    = {o, ~o, a, seg(tr), seg(tm < 0 ? 0 : tm)};
    x.m    = (tm < 0) ? 19'h7FF00 : 19'h7FFFF;
    return x;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_en(input logic [3:0] k);
    key_in = k; enlock = 1'b1; step(1);
    enlock = 1'b0; step(1);
  endtask

  task automatic pulse_cmp(input logic [3:0] k);
    key_in = k; encmp = 1'b1; step(1);
    encmp = 1'b0; step(1);
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase != p && n < 8) begin step(1); n++; end
    if (phase != p) begin
      checks++; failures++;
      $display("FAIL wait_phase: phase %0d, required %0d", phase, p);
    end
  endtask

  // Advance through the next tick cycle so its effect is visible.
  task automatic tick_step();
    wait_phase(3);
    step(1);
  endtask

  task automatic test_reset();
    rst = 1'b1; step(2);
    sb.push_back(mk("reset", 0, 0, 5, 5));
    rst = 1'b0; step(1);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("unset_ignores_cmp", 0, 0, 5, 5));
    pulse_cmp(4'h0);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_program_open();
    sb.push_back(mk("program", 0, 0, 5, 5));
    pulse_en(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    key_in = 4'b1010; encmp = 1'b1;
    sb.push_back(mk("open_edge1", 0, 0, 5, 5));
    step(1);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    encmp = 1'b0;
    sb.push_back(mk("open_edge2", 1, 0, 5, 5));
    step(1);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_exhaust_tries();
    sb.push_back(mk("rekey_armed", 0, 0, 5, 5));
    pulse_en(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(mk($sformatf("wrong_try%0d", i), 0, (i == 5), 5 - i, -1));
      pulse_cmp(4'b0001);
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    end
    sb.push_back(mk("alert_ignores_cmp", 0, 1, 0, -1));
    pulse_cmp(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_clear();
    sb.push_back(mk("clear_alert", 0, 0, 5, 5));
    clr_alert = 1'b1; step(1); clr_alert = 1'b0;
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("old_key_valid", 1, 0, 5, 5));
    pulse_cmp(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("clr_outside_alert", 1, 0, 5, 5));
    clr_alert = 1'b1; step(1); clr_alert = 1'b0;
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_auto_relock();
    pulse_en(4'b1010);
    sb.push_back(mk("reopen", 1, 0, 5, 5));
    pulse_cmp(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("open_after_2_ticks", 1, 0, 5, 5));
    tick_step(); tick_step();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("relocked_3_ticks", 0, 0, 5, 5));
    tick_step();
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("relock_is_armed", 1, 0, 5, 5));
    pulse_cmp(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("rekey_in_open", 0, 0, 5, 5));
    pulse_en(4'b0110);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("old_key_rejected", 0, 0, 4, -1));
    pulse_cmp(4'b1010);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("new_key_opens", 1, 0, 5, 5));
    pulse_cmp(4'b0110);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_timeout();
    pulse_en(4'b0110);
    wait_phase(0);
    sb.push_back(mk("timer_start", 0, 0, 4, 5));
    pulse_cmp(4'b0001);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    for (int t = 4; t >= 0; t--) begin
      sb.push_back(mk($sformatf("time_left%0d", t), 0, (t == 0), 4, t));
      tick_step();
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    end
    sb.push_back(mk("clear_timeout", 0, 0, 5, 5));
    clr_alert = 1'b1; step(1); clr_alert = 1'b0;
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  task automatic test_coincidence();
    for (int pass = 0; pass < 2; pass++) begin
      wait_phase(0);
      pulse_cmp(4'b0001);
      repeat (4) tick_step();
      sb.push_back(mk("before_final_tick", 0, 0, 4, 1));
      wait_phase(2);
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
      if (pass == 0) begin
        sb.push_back(mk("coinc_match_opens", 1, 0, 5, 5));
        pulse_cmp(4'b0110);
      end else begin
        sb.push_back(mk("coinc_miss_alerts", 0, 1, 3, 0));
        pulse_cmp(4'b0001);
      end
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
      if (pass == 0) pulse_en(4'b0110);
    end
    clr_alert = 1'b1; step(1); clr_alert = 1'b0;
  endtask

  task automatic test_back_to_back();
    sb.push_back(mk("held_acts_once", 0, 0, 4, -1));
    key_in = 4'b0001; encmp = 1'b1; step(4);
    encmp = 1'b0; step(1);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk($sformatf("b2b_try%0d", i), 0, 0, 3 - i, -1));
      pulse_cmp(4'b0011);
      e = sb.pop_front(); checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    end
  endtask

  task automatic test_reset_in_open();
    sb.push_back(mk("open_before_rst", 1, 0, 5, 5));
    pulse_cmp(4'b0110);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("rst_from_open", 0, 0, 5, 5));
    rst = 1'b1; step(1); rst = 1'b0;
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    sb.push_back(mk("unset_after_rst", 0, 0, 5, 5));
    pulse_cmp(4'b0110);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
    pulse_en(4'b0011);
    sb.push_back(mk("reprogram_open", 1, 0, 5, 5));
    pulse_cmp(4'b0011);
    e = sb.pop_front(); checks++;
    if ((obs & e.m) !== (e.v & e.m)) begin failures++; $display("FAIL %s: got %h required %h", e.name, obs & e.m, e.v & e.m); end
  endtask

  initial begin
    test_reset();
    test_program_open();
    test_exhaust_tries();
    test_clear();
    test_auto_relock();
    test_timeout();
    test_coincidence();
    test_back_to_back();
    test_reset_in_open();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/code_lock_ctrl.md
# code_lock_ctrl

Parametrised combination-lock controller: next generation of the 4-switch lock, with configurable key width, try limit, attempt timeout and auto-relock. It stores a key, compares entries on request, counts wrong attempts, runs a prescaled countdown, and raises a latched alert that only an explicit clear or reset removes. Two seven-segment digit outputs show remaining tries and remaining time. It sits between the switch/button inputs and the board LEDs and displays.

## Interface
Parameters:
- KEY_W, 4: key/entry width in bits.
- MAX_TRIES, 5: wrong attempts allowed; range 1..9.
- TICK_DIV, 100000000: clk cycles per tick; must be ≥2.
- TIMEOUT_TICKS, 5: ticks allowed after the first wrong attempt; range 1..9.
- OPEN_TICKS, 3: ticks before the lock auto-relocks from OPEN; must be ≥1.

Ports:
- clk  in  1  system clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- key_in  in  KEY_W  switch entry; synchronous to clk.
- enlock  in  1  program request; acts on its rising edge.
- encmp  in  1  compare request; acts on its rising edge.
- clr_alert  in  1  level; clears ALERT.
- open  out  1  high in OPEN.
- locked  out  1  equals ~open.
- alert  out  1  high in ALERT.
- tries_seg  out  8  seven-seg code of tries_left.
- time_seg  out  8  seven-seg code of time_left.

## Operation
- Edge detection: registered copies of enlock and encmp. An edge is the current value 1 with the previous value 0. Reset clears the copies to 0.
- Prescaler: free-running counter 0..TICK_DIV-1. `tick` is a 1-cycle pulse when the count equals TICK_DIV-1, then the count wraps to 0.
- Counters: tries_left and time_left, each 4 bits unsigned. They never underflow; a decrement at 0 holds 0. open_left counts the OPEN_TICKS window.
- States:
  - UNSET: no key stored.
    - enlock edge → key_reg←key_in; go to ARMED.
    - encmp ignored.
  - ARMED, on encmp edge:
    - key_in==key_reg → OPEN; tries_left←MAX_TRIES; time_left←TIMEOUT_TICKS; timer stops; open_left←OPEN_TICKS.
    - Mismatch → tries_left−1 and the timer runs. Reaching 0 → ALERT.
  - ARMED, on tick while the timer runs: time_left−1. Reaching 0 → ALERT.
  - ARMED, on enlock edge: ignored.
  - OPEN:
    - enlock edge → key_reg←key_in; go to ARMED (re-key).
    - tick → open_left−1. Reaching 0 → ARMED.
    - encmp ignored.
  - ALERT:
    - All requests ignored; counters frozen.
    - clr_alert=1 → ARMED; tries_left←MAX_TRIES; time_left←TIMEOUT_TICKS; timer stops. key_reg is kept.
- Priority within a single cycle: rst > clr_alert > encmp/enlock edge > tick.
  - A matching compare coinciding with the final timeout tick → OPEN.
  - A mismatch coinciding with that tick → ALERT.
  - clr_alert outside ALERT has no effect.
- Display encoding: segments active-high. Bit0=a … bit6=g; bit7 is the decimal point, held 0. Digits 0–9 use the standard patterns.

## Timing
- Reset values:
  - state=UNSET, key_reg=0, tries_left=MAX_TRIES, time_left=TIMEOUT_TICKS, prescaler=0.
  - open=0, locked=1, alert=0.
  - tries_seg and time_seg show those digits from the first cycle after reset.
- Request latency: a request sampled high at clock edge E (low at E−1) changes state at edge E+1. Outputs are registered and change at that same edge.
- A held request acts once. The input must return low for ≥1 cycle before the next edge is recognised.
- rst asserted mid-operation forces the reset values at the next edge, whatever the state.
- Tick-driven transitions occur at the edge following the tick cycle.

## Structure
- Package lock_pkg:
  - state enum (UNSET, ARMED, OPEN, ALERT);
  - seven-seg digit constants SEG_0..SEG_9 and SEG_BLANK.
- Sub-module seg7_digit: combinational 4-bit → 8-bit decoder, instantiated twice. Codes above 9 give SEG_BLANK.
- Everything else (prescaler, edge detectors, FSM, counters) lives in code_lock_ctrl.

## Test plan
All scenarios use TICK_DIV=4 and the other parameters at their defaults.
- Program and open:
  - Stimulus: rst; key_in=4'b1010 with an enlock pulse; then an encmp pulse with the same key.
  - Required: open=1 two edges after the encmp rise; tries_seg=SEG_5.
- Exhaust tries:
  - Stimulus: five encmp pulses with key_in=4'b0001.
  - Required: tries_left 4,3,2,1,0, then alert=1, open=0. A further correct compare keeps open=0.
- Timeout:
  - Stimulus: one wrong compare, then idle 5×4 cycles.
  - Required: time_seg counts 5→0, then alert=1.
- Auto-relock:
  - Stimulus: open the lock, then wait 3 ticks.
  - Required: open=0, state ARMED. An enlock pulse while OPEN stores the new key.
- Coincidence:
  - Stimulus: a correct encmp edge in the same cycle as the final timeout tick.
  - Required: OPEN, not ALERT.
- Clear and reset:
  - Stimulus: clr_alert=1 in ALERT → ARMED with tries 5 and the old key still valid. rst asserted while OPEN.
  - Required: after the rst, UNSET with all reset values.
